pattern_checker: RTL and testbench

Parametrised receive-side data checker for the write-path bandwidth tests. Each accepted data beat is compared against an internally generated reference sequence selected by a latched pattern code. The block counts checked beats and mismatches, and captures the first failing beat for host readback. It replaces the fixed 64-bit single-pattern checker and adds a valid qualifier, a start handshake, an armed/run state machine, saturating counters and first-error capture.

---
 rtl/pattern_checker.sv | 192 +++++++++++++++++++
 tb/tb_pattern_checker.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_checker.sv
// pattern_checker: receive-side beat checker against a reference sequence picked by a latched code.
// Build option: define PATTERN_CHECKER_RESYNC_EN to seed COUNT/COUNT28 from the first accepted beat.
module pattern_checker #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        pattern,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic              clear_errors,
  output logic [CNT_W-1:0]  error_count,
  output logic [CNT_W-1:0]  word_count,
  output logic              error_flag,
  output logic              err_sat,
  output logic [CNT_W-1:0]  first_err_index,
  output logic [DATA_W-1:0] first_err_data,
  output logic [DATA_W-1:0] first_err_expected,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;

  localparam logic [2:0]        P_COUNT   = 3'd0;
  localparam logic [2:0]        P_WALK1   = 3'd1;
  localparam logic [2:0]        P_ALT     = 3'd2;
  localparam logic [2:0]        P_COUNT28 = 3'd3;
  localparam logic [2:0]        P_PRBS    = 3'd4;
  localparam logic [31:0]       LFSR_SEED = 32'hFFFF_FFFF;
  localparam logic [31:0]       LFSR_TAPS = 32'h8020_0003;
  localparam logic [DATA_W-1:0] ALT_EVEN  = {(DATA_W/2){2'b01}};
  localparam logic [DATA_W-1:0] WALK_INIT = {{(DATA_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [2:0]        pat_q, pat_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] walk_q, walk_d;
  logic [31:0]       lfsr_q, lfsr_d;
  logic [CNT_W-1:0]  wc_q, wc_d;
  logic [CNT_W-1:0]  ec_q, ec_d;
  logic              flag_q, flag_d;
  logic              sat_q, sat_d;
  logic [CNT_W-1:0]  fidx_q, fidx_d;
  logic [DATA_W-1:0] fdat_q, fdat_d;
  logic [DATA_W-1:0] fexp_q, fexp_d;
  // Compare stage: beat, reference and mask captured on accept, evaluated one edge later
  logic              pv_q, pv_d;
  logic [CNT_W-1:0]  pidx_q, pidx_d;
  logic [DATA_W-1:0] pdat_q, pdat_d;
  logic [DATA_W-1:0] pexp_q, pexp_d;
  logic [DATA_W-1:0] pmask_q, pmask_d;

  logic              accept;
  logic              seed_beat;
  logic              mismatch;
  logic [DATA_W-1:0] ref_word;
  logic [DATA_W-1:0] ref_mask;

  assign accept = data_valid && (state_q != IDLE) && !start;
`ifdef PATTERN_CHECKER_RESYNC_EN
  assign seed_beat = accept && (state_q == ARMED) && ((pat_q == P_COUNT) || (pat_q == P_COUNT28));
`else
  assign seed_beat = 1'b0;
`endif
  assign mismatch = pv_q && (((pdat_q ^ pexp_q) & pmask_q) != '0);

  // cnt_q tracks k except after a resync seed, so its LSB doubles as the ALT phase
  always_comb begin
    ref_word = cnt_q;
    ref_mask = '1;
    case (pat_q)
      P_COUNT:   ref_word = cnt_q;
      P_WALK1:   ref_word = walk_q;
      P_ALT:     ref_word = cnt_q[0] ? ~ALT_EVEN : ALT_EVEN;
      P_COUNT28: begin
        ref_mask       = '0;
        ref_mask[27:0] = '1;
      end
      P_PRBS:    ref_word = {(DATA_W/32){lfsr_q}};
      default:   ref_mask = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    walk_d  = walk_q;
    lfsr_d  = lfsr_q;
    wc_d    = wc_q;
    ec_d    = ec_q;
    flag_d  = flag_q;
    sat_d   = sat_q;
    fidx_d  = fidx_q;
    fdat_d  = fdat_q;
    fexp_d  = fexp_q;
    pv_d    = accept && !seed_beat;
    pidx_d  = wc_q;
    pdat_d  = data_in;
    pexp_d  = ref_word;
    pmask_d = ref_mask;
    if (start) begin
      state_d = ARMED;
      pat_d   = pattern;
      cnt_d   = '0;
      walk_d  = WALK_INIT;
      lfsr_d  = LFSR_SEED;
      wc_d    = '0;
      ec_d    = '0;
      flag_d  = 1'b0;
      sat_d   = 1'b0;
      fidx_d  = '0;
      fdat_d  = '0;
      fexp_d  = '0;
    end else begin
      if (clear_errors) begin
        ec_d   = '0;
        flag_d = 1'b0;
        sat_d  = 1'b0;
        fidx_d = '0;
        fdat_d = '0;
        fexp_d = '0;
      end else if (mismatch) begin
        if (ec_q != '1) ec_d = ec_q + 1'b1;
        if (ec_d == '1) sat_d = 1'b1;
        flag_d = 1'b1;
        if (!flag_q) begin
          fidx_d = pidx_q;
          fdat_d = pdat_q;
          fexp_d = pexp_q;
        end
      end
      if (accept) begin
        state_d = RUN;
        wc_d    = wc_q + 1'b1;
        cnt_d   = seed_beat ? data_in + 1'b1 : cnt_q + 1'b1;
        walk_d  = {walk_q[DATA_W-2:0], walk_q[DATA_W-1]};
        lfsr_d  = {lfsr_q[30:0], ^(lfsr_q & LFSR_TAPS)};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pat_q   <= P_COUNT;
      cnt_q   <= '0;
      walk_q  <= WALK_INIT;
      lfsr_q  <= LFSR_SEED;
      wc_q    <= '0;
      ec_q    <= '0;
      flag_q  <= 1'b0;
      sat_q   <= 1'b0;
      fidx_q  <= '0;
      fdat_q  <= '0;
      fexp_q  <= '0;
      pv_q    <= 1'b0;
      pidx_q  <= '0;
      pdat_q  <= '0;
      pexp_q  <= '0;
      pmask_q <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      walk_q  <= walk_d;
      lfsr_q  <= lfsr_d;
      wc_q    <= wc_d;
      ec_q    <= ec_d;
      flag_q  <= flag_d;
      sat_q   <= sat_d;
      fidx_q  <= fidx_d;
      fdat_q  <= fdat_d;
      fexp_q  <= fexp_d;
      pv_q    <= pv_d;
      pidx_q  <= pidx_d;
      pdat_q  <= pdat_d;
      pexp_q  <= pexp_d;
      pmask_q <= pmask_d;
    end
  end

  assign error_count        = ec_q;
  assign word_count         = wc_q;
  assign error_flag         = flag_q;
  assign err_sat            = sat_q;
  assign first_err_index    = fidx_q;
  assign first_err_data     = fdat_q;
  assign first_err_expected = fexp_q;
  assign busy               = (state_q != IDLE);
endmodule

// File: tb/tb_pattern_checker.sv
// Scoreboard bench for pattern_checker: a beat-level reference model predicts every output after each edge.
module tb_pattern_checker;
  localparam int DATA_W = 64;
  localparam int CNT_W  = 6;
  localparam int EC_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [2:0]        pattern = 3'd0;
  logic              data_valid = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic              clear_errors = 1'b0;
  logic [CNT_W-1:0]  error_count, word_count, first_err_index;
  logic              error_flag, err_sat, busy;
  logic [DATA_W-1:0] first_err_data, first_err_expected;

  pattern_checker #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern),
    .data_valid(data_valid), .data_in(data_in), .clear_errors(clear_errors),
    .error_count(error_count), .word_count(word_count), .error_flag(error_flag),
    .err_sat(err_sat), .first_err_index(first_err_index), .first_err_data(first_err_data),
    .first_err_expected(first_err_expected), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CNT_W-1:0]  ec, wc, fi;
    logic              flag, sat, busy;
    logic [DATA_W-1:0] fd, fe;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state: beats since start (n), COUNT base, counters, pending compare result
  int                m_state = 0;
  logic [2:0]        m_pat = 3'd0;
  int                m_n = 0;
  logic [DATA_W-1:0] m_base = '0;
  int                m_wc = 0, m_ec = 0, m_fi = 0;
  logic              m_flag = 1'b0, m_sat = 1'b0;
  logic [DATA_W-1:0] m_fd = '0, m_fe = '0;
  logic              pend_v = 1'b0;
  int                pend_idx = 0;
  logic [DATA_W-1:0] pend_d = '0, pend_e = '0;
  logic [31:0]       prbs_q[$];

  function automatic logic [DATA_W-1:0] prbs_word(int n);
    logic [31:0] s;
    while (prbs_q.size() <= n) begin
      s = prbs_q[prbs_q.size()-1];
      prbs_q.push_back({s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]});
    end
    return {(DATA_W/32){prbs_q[n]}};
  endfunction

  function automatic logic [DATA_W-1:0] exp_word(int n);
    logic [DATA_W-1:0] one = 1;
    case (m_pat)
      3'd0, 3'd3: return m_base + DATA_W'(n);
      3'd1:       return one << (n % DATA_W);
      3'd2:       return (n % 2 == 0) ? {(DATA_W/2){2'b01}} : {(DATA_W/2){2'b10}};
      3'd4:       return prbs_word(n);
      default:    return '0;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] cmp_mask();
    logic [DATA_W-1:0] m = '1;
    if (m_pat == 3'd3) m = 64'h0FFF_FFFF;
    else if (m_pat > 3'd4) m = '0;
    return m;
  endfunction

  task automatic clr_errs();
    m_ec = 0; m_flag = 1'b0; m_sat = 1'b0; m_fi = 0; m_fd = '0; m_fe = '0;
  endtask

  task automatic model(input logic rst, input logic st, input logic [2:0] pat,
                       input logic dv, input logic [DATA_W-1:0] din, input logic clr);
    exp_t e;
    logic resync;
    if (rst) begin
      m_state = 0; m_pat = 3'd0; m_n = 0; m_base = '0; m_wc = 0; pend_v = 1'b0;
      clr_errs();
    end else begin
      if (pend_v && !st && !clr) begin
        if (m_ec < EC_MAX) m_ec++;
        if (m_ec == EC_MAX) m_sat = 1'b1;
        if (!m_flag) begin m_fi = pend_idx; m_fd = pend_d; m_fe = pend_e; end
        m_flag = 1'b1;
      end
      if (clr && !st) clr_errs();
      pend_v = 1'b0;
      if (st) begin
        m_state = 1; m_pat = pat; m_n = 0; m_base = '0; m_wc = 0;
        clr_errs();
      end else if (dv && m_state != 0) begin
`ifdef PATTERN_CHECKER_RESYNC_EN
        resync = (m_state == 1) && (m_pat == 3'd0 || m_pat == 3'd3);
`else
        resync = 1'b0;
`endif
        if (resync) m_base = din;
        else if (((din ^ exp_word(m_n)) & cmp_mask()) != '0) begin
          pend_v = 1'b1; pend_idx = m_wc; pend_d = din; pend_e = exp_word(m_n);
        end
        m_n++; m_wc++; m_state = 2;
      end
    end
    e.ec = CNT_W'(m_ec); e.wc = CNT_W'(m_wc); e.fi = CNT_W'(m_fi);
    e.flag = m_flag; e.sat = m_sat; e.busy = (m_state != 0);
    e.fd = m_fd; e.fe = m_fe;
    sb.push_back(e);
  endtask

  // One clock: drive after the monitor's edge, predict the state after the next rising edge
  task automatic cyc(input logic rst, input logic st, input logic [2:0] pat,
                     input logic dv, input logic [DATA_W-1:0] din, input logic clr);
    @(negedge clk);
    #1;
    reset = rst; start = st; pattern = pat; data_valid = dv; data_in = din; clear_errors = clr;
    model(rst, st, pat, dv, din, clr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 3'd0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_start(input logic [2:0] pat);
    cyc(1'b0, 1'b1, pat, 1'b0, '0, 1'b0);
  endtask

  task automatic good_beat(input logic clr);
    cyc(1'b0, 1'b0, 3'd0, 1'b1, exp_word(m_n), clr);
  endtask

  task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("word_count", DATA_W'(word_count), DATA_W'(e.wc));
      chk("error_count", DATA_W'(error_count), DATA_W'(e.ec));
      chk("error_flag", DATA_W'(error_flag), DATA_W'(e.flag));
      chk("err_sat", DATA_W'(err_sat), DATA_W'(e.sat));
      chk("busy", DATA_W'(busy), DATA_W'(e.busy));
      chk("first_err_index", DATA_W'(first_err_index), DATA_W'(e.fi));
      chk("first_err_data", first_err_data, e.fd);
      chk("first_err_expected", first_err_expected, e.fe);
    end
  end

  initial begin
    logic [DATA_W-1:0] d;
    logic [2:0] p;
    int len;
    prbs_q.push_back(32'hFFFF_FFFF);
    repeat (3) cyc(1'b1, 1'b0, 3'd0, 1'b0, '0, 1'b0);
    idle(2);

    // COUNT, clean stream, one beat per cycle
    do_start(3'd0);
    for (int k = 0; k < 16; k++) cyc(1'b0, 1'b0, 3'd0, 1'b1, DATA_W'(k), 1'b0);
    idle(3);
    // COUNT with beat 5 corrupted
    do_start(3'd0);
    for (int k = 0; k < 16; k++) cyc(1'b0, 1'b0, 3'd0, 1'b1, (k == 5) ? 64'hDEAD : DATA_W'(k), 1'b0);
    idle(3);
    // Junk above bit 27: ignored by COUNT28, flagged by COUNT
    for (int p2 = 3; p2 >= 0; p2 -= 3) begin
      do_start(3'(p2));
      for (int k = 0; k < 16; k++) cyc(1'b0, 1'b0, 3'd0, 1'b1, DATA_W'(k) | (64'hF << 28), 1'b0);
      idle(3);
    end
    // PRBS: 3 good, 2 bad, good beat with clear on the second mismatch result
    do_start(3'd4);
    repeat (3) good_beat(1'b0);
    repeat (2) cyc(1'b0, 1'b0, 3'd0, 1'b1, ~exp_word(m_n), 1'b0);
    good_beat(1'b1);
    idle(3);
    // Saturate error_count, then reset mid-stream
    do_start(3'd1);
    repeat (70) cyc(1'b0, 1'b0, 3'd0, 1'b1, ~exp_word(m_n), 1'b0);
    cyc(1'b1, 1'b0, 3'd0, 1'b1, '0, 1'b0);
    idle(3);
    // Seed-able COUNT stream
    do_start(3'd0);
    for (int k = 100; k < 103; k++) cyc(1'b0, 1'b0, 3'd0, 1'b1, DATA_W'(k), 1'b0);
    idle(3);
    // Held start keeps the block armed and ignores beats
    repeat (3) cyc(1'b0, 1'b1, 3'd2, 1'b1, '0, 1'b0);
    repeat (6) good_beat(1'b0);

    // Randomized runs over all codes
    for (int r = 0; r < 24; r++) begin
      p = 3'($urandom_range(0, 7));
      do_start(p);
      len = $urandom_range(10, 40);
      for (int i = 0; i < len; i++) begin
        d = exp_word(m_n);
        if ($urandom_range(0, 7) == 0) d = d ^ (64'h1 << $urandom_range(0, 63));
        if ($urandom_range(0, 9) == 0) d = {$urandom, $urandom};
        cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 59) == 0), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 3) != 0), d, ($urandom_range(0, 29) == 0));
      end
      idle($urandom_range(0, 2));
    end
    idle(2);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d predictions left, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
